// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Package  : hazard_pkg
// Brief    : Shared FSM state and forwarding-select encodings for the
//            hazard scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } fsm_state_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10,
    FWD_LWB   = 2'b11
  } fwd_sel_t;

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
// Module   : fwd_select
// Brief    : ALU operand bypass selection for one source register.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_select
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs,
  input  logic          ex_mem_reg_write,
  input  logic [AW-1:0] ex_mem_rd,
  input  logic          mem_wb_reg_write,
  input  logic [AW-1:0] mem_wb_rd,
  input  logic          lwb_valid,
  input  logic [AW-1:0] lwb_rd,
  output fwd_sel_t      sel
);

  // Youngest producer wins; the long-op writeback port is the last resort.
  always_comb begin
    sel = FWD_RF;
    if (ex_mem_reg_write && (ex_mem_rd != '0) && (ex_mem_rd == rs)) begin
      sel = FWD_EXMEM;
    end else if (mem_wb_reg_write && (mem_wb_rd != '0) && (mem_wb_rd == rs)) begin
      sel = FWD_MEMWB;
    end else if (lwb_valid && (lwb_rd != '0) && (lwb_rd == rs)) begin
      sel = FWD_LWB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Pipeline hazard unit: forwarding, load-use/RAW/WAW stall,
//            branch flush, long-op busy scoreboard and stall watchdog.
//            Optional HZD_PERF_EN adds a stall-cycle performance counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW      = 5,
  parameter int NREG    = 32,
  parameter int MAX_OUT = 4,
  parameter int TMO     = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic          id_rs1_used,
  input  logic          id_rs2_used,
  input  logic          id_is_long,
  input  logic [AW-1:0] id_rd,
  input  logic [AW-1:0] ex_rs1,
  input  logic [AW-1:0] ex_rs2,
  input  logic [AW-1:0] id_ex_rd,
  input  logic          id_ex_mem_read,
  input  logic [AW-1:0] ex_mem_rd,
  input  logic [AW-1:0] mem_wb_rd,
  input  logic          ex_mem_reg_write,
  input  logic          mem_wb_reg_write,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic          lwb_valid,
  input  logic [AW-1:0] lwb_rd,
  input  logic          branch_taken,
  output logic [1:0]    forward_a,
  output logic [1:0]    forward_b,
  output logic          pc_write,
  output logic          if_id_write,
  output logic          control_mux_sig,
  output logic          if_id_flush,
  output logic          issue_ready,
  output logic          hazard_timeout
`ifdef HZD_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt
`endif
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int WW = $clog2(TMO + 1);
  localparam logic [CW-1:0] c_max_out = CW'(MAX_OUT);
  localparam logic [WW-1:0] c_tmo     = WW'(TMO);

  fsm_state_t      r_state, w_state_nxt;
  logic [NREG-1:0] r_busy, w_busy_nxt;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [WW-1:0]   r_wait, w_wait_nxt;
  logic            r_timeout;
  logic            w_issue_acc, w_lwb_dec;
  logic            w_load_use, w_raw, w_waw, w_hazard;
  fwd_sel_t        w_fwd_a, w_fwd_b;

  fwd_select #(.AW(AW)) u_fwd_a (
    .rs               (ex_rs1),
    .ex_mem_reg_write (ex_mem_reg_write),
    .ex_mem_rd        (ex_mem_rd),
    .mem_wb_reg_write (mem_wb_reg_write),
    .mem_wb_rd        (mem_wb_rd),
    .lwb_valid        (lwb_valid),
    .lwb_rd           (lwb_rd),
    .sel              (w_fwd_a)
  );

  fwd_select #(.AW(AW)) u_fwd_b (
    .rs               (ex_rs2),
    .ex_mem_reg_write (ex_mem_reg_write),
    .ex_mem_rd        (ex_mem_rd),
    .mem_wb_reg_write (mem_wb_reg_write),
    .mem_wb_rd        (mem_wb_rd),
    .lwb_valid        (lwb_valid),
    .lwb_rd           (lwb_rd),
    .sel              (w_fwd_b)
  );

  assign w_load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                      ((id_rs1_used && (id_rs1 == id_ex_rd)) ||
                       (id_rs2_used && (id_rs2 == id_ex_rd)));

  // A source being written back this cycle is released immediately (bypassed via lwb).
  assign w_raw = (id_rs1_used && r_busy[id_rs1] && !(lwb_valid && (lwb_rd == id_rs1))) ||
                 (id_rs2_used && r_busy[id_rs2] && !(lwb_valid && (lwb_rd == id_rs2)));

  assign w_waw    = id_is_long && (r_busy[id_rd] || (r_count == c_max_out));
  assign w_hazard = w_load_use || w_raw || w_waw;

  // A slot freed by this cycle's writeback may be reused by a same-cycle issue.
  assign w_issue_acc = issue_valid && ((r_count < c_max_out) || lwb_valid);
  assign w_lwb_dec   = lwb_valid && (r_count != '0);

  always_comb begin
    w_busy_nxt = r_busy;
    if (lwb_valid) begin
      w_busy_nxt[lwb_rd] = 1'b0;
    end
    if (w_issue_acc) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;

    w_count_nxt = r_count;
    if (w_issue_acc && !w_lwb_dec) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_issue_acc && w_lwb_dec) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_comb begin
    w_state_nxt     = RUN;
    pc_write        = 1'b1;
    if_id_write     = 1'b1;
    control_mux_sig = 1'b0;
    if_id_flush     = 1'b0;
    if (branch_taken) begin
      w_state_nxt = FLUSH;
    end else if (w_hazard) begin
      w_state_nxt = STALL;
    end
    if (rst_n) begin
      case (w_state_nxt)
        STALL: begin
          pc_write        = 1'b0;
          if_id_write     = 1'b0;
          control_mux_sig = 1'b1;
        end
        FLUSH: begin
          if_id_flush     = 1'b1;
          control_mux_sig = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_wait_nxt = '0;
    if (w_state_nxt == STALL) begin
      if (r_state != STALL) begin
        w_wait_nxt = WW'(1);
      end else if (r_wait == c_tmo) begin
        w_wait_nxt = r_wait;
      end else begin
        w_wait_nxt = r_wait + WW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_busy    <= '0;
      r_count   <= '0;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_count <= w_count_nxt;
      r_wait  <= w_wait_nxt;
      if (w_wait_nxt == c_tmo) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign forward_a      = rst_n ? w_fwd_a : FWD_RF;
  assign forward_b      = rst_n ? w_fwd_b : FWD_RF;
  assign issue_ready    = rst_n && (r_count < c_max_out);
  assign hazard_timeout = r_timeout;

`ifdef HZD_PERF_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf <= '0;
    end else if (w_state_nxt == STALL) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Brief    : Self-checking bench for hazard_scoreboard against a queue-based
//            model of outstanding long-latency destinations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  localparam int AW      = 5;
  localparam int NREG    = 32;
  localparam int MAX_OUT = 4;
  localparam int TMO     = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] id_rs1, id_rs2, id_rd, ex_rs1, ex_rs2, id_ex_rd;
  logic [AW-1:0] ex_mem_rd, mem_wb_rd, issue_rd, lwb_rd;
  logic id_rs1_used, id_rs2_used, id_is_long, id_ex_mem_read;
  logic ex_mem_reg_write, mem_wb_reg_write, issue_valid, lwb_valid, branch_taken;
  logic [1:0] forward_a, forward_b;
  logic pc_write, if_id_write, control_mux_sig, if_id_flush, issue_ready, hazard_timeout;
`ifdef HZD_PERF_EN
  logic [31:0] perf_stall_cnt;
  int m_perf = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: destinations of outstanding long ops, consecutive stall count, sticky flag
  int q[$];
  int waitc = 0;
  bit tmo   = 1'b0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.AW(AW), .NREG(NREG), .MAX_OUT(MAX_OUT), .TMO(TMO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_rs1_used      (id_rs1_used),
    .id_rs2_used      (id_rs2_used),
    .id_is_long       (id_is_long),
    .id_rd            (id_rd),
    .ex_rs1           (ex_rs1),
    .ex_rs2           (ex_rs2),
    .id_ex_rd         (id_ex_rd),
    .id_ex_mem_read   (id_ex_mem_read),
    .ex_mem_rd        (ex_mem_rd),
    .mem_wb_rd        (mem_wb_rd),
    .ex_mem_reg_write (ex_mem_reg_write),
    .mem_wb_reg_write (mem_wb_reg_write),
    .issue_valid      (issue_valid),
    .issue_rd         (issue_rd),
    .lwb_valid        (lwb_valid),
    .lwb_rd           (lwb_rd),
    .branch_taken     (branch_taken),
    .forward_a        (forward_a),
    .forward_b        (forward_b),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .control_mux_sig  (control_mux_sig),
    .if_id_flush      (if_id_flush),
    .issue_ready      (issue_ready),
    .hazard_timeout   (hazard_timeout)
`ifdef HZD_PERF_EN
    ,
    .perf_stall_cnt   (perf_stall_cnt)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit busy_m(input logic [AW-1:0] r);
    if (r == '0) return 1'b0;
    foreach (q[i]) if (q[i] == int'(r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int fwd_m(input logic [AW-1:0] rs);
    if (ex_mem_reg_write && ex_mem_rd != '0 && ex_mem_rd == rs) return 2;
    if (mem_wb_reg_write && mem_wb_rd != '0 && mem_wb_rd == rs) return 1;
    if (lwb_valid && lwb_rd != '0 && lwb_rd == rs) return 3;
    return 0;
  endfunction

  function automatic bit src_raw(input logic used, input logic [AW-1:0] r);
    return used && busy_m(r) && !(lwb_valid && lwb_rd == r);
  endfunction

  // 0 = run, 1 = stall, 2 = flush
  function automatic int decision_m();
    bit lu, waw;
    lu  = id_ex_mem_read && id_ex_rd != '0 &&
          ((id_rs1_used && id_rs1 == id_ex_rd) || (id_rs2_used && id_rs2 == id_ex_rd));
    waw = id_is_long && (busy_m(id_rd) || q.size() == MAX_OUT);
    if (branch_taken) return 2;
    if (lu || waw || src_raw(id_rs1_used, id_rs1) || src_raw(id_rs2_used, id_rs2)) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin : cmp
    int d;
    if (!rst_n) begin
      chk("rst_pc_write", 32'(pc_write), 1);
      chk("rst_if_id_write", 32'(if_id_write), 1);
      chk("rst_control_mux_sig", 32'(control_mux_sig), 0);
      chk("rst_if_id_flush", 32'(if_id_flush), 0);
      chk("rst_forward_a", 32'(forward_a), 0);
      chk("rst_forward_b", 32'(forward_b), 0);
      chk("rst_issue_ready", 32'(issue_ready), 0);
      chk("rst_hazard_timeout", 32'(hazard_timeout), 0);
    end else begin
      d = decision_m();
      chk("pc_write", 32'(pc_write), 32'(d != 1));
      if (d != 2) chk("if_id_write", 32'(if_id_write), 32'(d == 0));
      chk("control_mux_sig", 32'(control_mux_sig), 32'(d != 0));
      chk("if_id_flush", 32'(if_id_flush), 32'(d == 2));
      chk("forward_a", 32'(forward_a), fwd_m(ex_rs1));
      chk("forward_b", 32'(forward_b), fwd_m(ex_rs2));
      chk("issue_ready", 32'(issue_ready), 32'(q.size() < MAX_OUT));
      chk("hazard_timeout", 32'(hazard_timeout), 32'(tmo));
`ifdef HZD_PERF_EN
      chk("perf_stall_cnt", int'(perf_stall_cnt), m_perf);
`endif
    end
  end

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; ex_rs1 = '0; ex_rs2 = '0; id_ex_rd = '0;
    ex_mem_rd = '0; mem_wb_rd = '0; issue_rd = '0; lwb_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_is_long = 1'b0; id_ex_mem_read = 1'b0;
    ex_mem_reg_write = 1'b0; mem_wb_reg_write = 1'b0; issue_valid = 1'b0;
    lwb_valid = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic model_clear();
    q.delete();
    waitc = 0;
    tmo = 1'b0;
`ifdef HZD_PERF_EN
    m_perf = 0;
`endif
  endtask

  // Advance one clock and apply the cycle's effects to the model.
  task automatic tick();
    int d;
    bit acc;
    @(posedge clk);
    if (rst_n) begin
      d   = decision_m();
      acc = issue_valid && (q.size() < MAX_OUT || lwb_valid);
      if (lwb_valid) begin
        for (int i = 0; i < q.size(); i++) begin
          if (q[i] == int'(lwb_rd)) begin
            q.delete(i);
            break;
          end
        end
      end
      if (acc) q.push_back(int'(issue_rd));
      if (d == 1) begin
        waitc++;
        if (waitc >= TMO) tmo = 1'b1;
`ifdef HZD_PERF_EN
        m_perf++;
`endif
      end else begin
        waitc = 0;
      end
    end
    #1;
  endtask

  task automatic rand_cycle();
    int r;
    id_rs1 = AW'($urandom_range(0, 7));
    id_rs2 = AW'($urandom_range(0, 7));
    id_rs1_used = ($urandom_range(0, 3) != 0);
    id_rs2_used = ($urandom_range(0, 1) != 0);
    id_is_long = ($urandom_range(0, 3) == 0);
    id_rd = AW'($urandom_range(0, 15));
    ex_rs1 = AW'($urandom_range(0, 7));
    ex_rs2 = AW'($urandom_range(0, 7));
    id_ex_mem_read = ($urandom_range(0, 9) < 3);
    id_ex_rd = AW'($urandom_range(0, 7));
    ex_mem_reg_write = ($urandom_range(0, 1) != 0);
    mem_wb_reg_write = ($urandom_range(0, 1) != 0);
    ex_mem_rd = AW'($urandom_range(0, 7));
    mem_wb_rd = AW'($urandom_range(0, 7));
    branch_taken = ($urandom_range(0, 9) == 0);
    lwb_valid = 1'b0;
    lwb_rd = AW'($urandom_range(0, 15));
    if (q.size() > 0 && $urandom_range(0, 9) < 4) begin
      lwb_valid = 1'b1;
      lwb_rd = AW'(q[$urandom_range(0, q.size() - 1)]);
    end
    issue_valid = 1'b0;
    issue_rd = '0;
    if ($urandom_range(0, 9) < 4) begin
      for (int k = 0; k < 50; k++) begin
        r = $urandom_range(1, 15);
        if (!busy_m(AW'(r))) begin
          issue_valid = 1'b1;
          issue_rd = AW'(r);
          break;
        end
      end
    end
  endtask

  initial begin
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    // Reset forces the run outputs even with a load-use pattern and a forward hit present
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b1;
    ex_mem_reg_write = 1'b1; ex_mem_rd = 5'd3; ex_rs1 = 5'd3;
    #2;
    chk("reset_pc_write", 32'(pc_write), 1);
    chk("reset_control_mux", 32'(control_mux_sig), 0);
    chk("reset_forward_a", 32'(forward_a), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    tick();

    // Forwarding priority
    ex_mem_reg_write = 1'b1; ex_mem_rd = 5'd5; mem_wb_reg_write = 1'b1; mem_wb_rd = 5'd5;
    ex_rs1 = 5'd5; ex_rs2 = 5'd5;
    #2;
    chk("fwd_exmem_a", 32'(forward_a), 2);
    chk("fwd_exmem_b", 32'(forward_b), 2);
    chk("model_fwd_exmem", fwd_m(ex_rs1), 2);
    tick();
    ex_mem_reg_write = 1'b0;
    #2;
    chk("fwd_memwb_a", 32'(forward_a), 1);
    tick();
    ex_mem_reg_write = 1'b1; ex_mem_rd = 5'd0; mem_wb_rd = 5'd0; ex_rs1 = 5'd0;
    #2;
    chk("fwd_x0_a", 32'(forward_a), 0);
    tick();
    idle();

    // Load-use: one stall, then run
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b1;
    #2;
    chk("loaduse_pc_write", 32'(pc_write), 0);
    chk("loaduse_control_mux", 32'(control_mux_sig), 1);
    tick();
    id_ex_mem_read = 1'b0;
    #2;
    chk("loaduse_release_pc_write", 32'(pc_write), 1);
    chk("loaduse_release_mux", 32'(control_mux_sig), 0);
    tick();
    idle();

    // RAW on a long op released by its writeback
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0; id_rs1 = 5'd9; id_rs1_used = 1'b1;
    #2;
    chk("raw_stall_1", 32'(pc_write), 0);
    chk("model_raw_stall", decision_m(), 1);
    tick();
    #2;
    chk("raw_stall_2", 32'(pc_write), 0);
    tick();
    lwb_valid = 1'b1; lwb_rd = 5'd9; ex_rs1 = 5'd9;
    #2;
    chk("raw_release", 32'(pc_write), 1);
    chk("raw_fwd_lwb", 32'(forward_a), 3);
    tick();
    idle();

    // Fill the scoreboard
    for (int i = 0; i < MAX_OUT; i++) begin
      issue_valid = 1'b1; issue_rd = AW'(10 + i);
      tick();
    end
    issue_valid = 1'b0;
    #2;
    chk("full_issue_ready", 32'(issue_ready), 0);
    issue_valid = 1'b1; issue_rd = 5'd20;
    tick();
    issue_valid = 1'b0; id_rs1 = 5'd20; id_rs1_used = 1'b1;
    #2;
    chk("ignored_issue_no_stall", 32'(pc_write), 1);
    tick();
    idle();
    lwb_valid = 1'b1; lwb_rd = 5'd10; issue_valid = 1'b1; issue_rd = 5'd14;
    tick();
    idle();
    id_rs1 = 5'd14; id_rs1_used = 1'b1;
    #2;
    chk("swap_still_full", 32'(issue_ready), 0);
    chk("swap_busy_x14", 32'(pc_write), 0);
    tick();
    idle();
    lwb_valid = 1'b1; lwb_rd = 5'd11;
    tick();
    idle();
    #2;
    chk("after_lwb_ready", 32'(issue_ready), 1);
    issue_valid = 1'b1; issue_rd = 5'd12; lwb_valid = 1'b1; lwb_rd = 5'd12;
    tick();
    idle();
    id_rs2 = 5'd12; id_rs2_used = 1'b1;
    #2;
    chk("same_rd_stays_busy", 32'(pc_write), 0);
    tick();
    idle();
    while (q.size() > 0) begin
      lwb_valid = 1'b1; lwb_rd = AW'(q[0]);
      tick();
    end
    idle();

    // Branch overrides a load-use stall
    id_ex_mem_read = 1'b1; id_ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b1;
    tick();
    branch_taken = 1'b1;
    #2;
    chk("branch_if_id_flush", 32'(if_id_flush), 1);
    chk("branch_pc_write", 32'(pc_write), 1);
    chk("branch_control_mux", 32'(control_mux_sig), 1);
    tick();
    idle();
    #2;
    chk("after_flush_run", 32'(if_id_flush), 0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rand_cycle();
      tick();
    end
    idle();
    while (q.size() > 0) begin
      lwb_valid = 1'b1; lwb_rd = AW'(q[0]);
      tick();
    end
    idle();
    tick();

    // Watchdog
    issue_valid = 1'b1; issue_rd = 5'd20;
    tick();
    issue_valid = 1'b0; id_rs1 = 5'd20; id_rs1_used = 1'b1;
    repeat (TMO - 1) tick();
    #2;
    chk("tmo_not_yet", 32'(hazard_timeout), 0);
    tick();
    #2;
    chk("tmo_set", 32'(hazard_timeout), 1);
    lwb_valid = 1'b1; lwb_rd = 5'd20;
    tick();
    idle();
    #2;
    chk("tmo_sticky", 32'(hazard_timeout), 1);
    tick();

    // Asynchronous reset in the middle of a RAW stall
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_valid = 1'b0; id_rs1 = 5'd3; id_rs1_used = 1'b1;
    #2;
    chk("pre_reset_stall", 32'(pc_write), 0);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("async_rst_tmo", 32'(hazard_timeout), 0);
    chk("async_rst_pc_write", 32'(pc_write), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    chk("post_reset_busy_gone", 32'(pc_write), 1);
    chk("post_reset_ready", 32'(issue_ready), 1);
    tick();
    idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
